// File: rtl/mem_port_arbiter_if.sv
// Bundle of signals between the arbiter, the core (fetch and load/store
// requesters) and the single-ported unified memory.
// The slave modport is the arbiter's view. The master modport is the
// environment's view: the core and the memory together.
`timescale 1ns/1ps
interface mem_port_arbiter_if;
  // instruction-fetch requester
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  // load/store requester
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ack;
  logic [31:0] d_rdata;
  // status back to the core
  logic        err;
  logic        core_stall;
  // memory port
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  mem_rdata, mem_ready,
    output if_ack, if_rdata, d_ack, d_rdata, err, core_stall,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
    output mem_rdata, mem_ready,
    input  if_ack, if_rdata, d_ack, d_rdata, err, core_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// Data wins when both ask, except that fetch is forced through after
// STARVE_MAX consecutive data grants. A watchdog aborts an access when the
// memory has not answered after TIMEOUT busy cycles, and returns err=1
// together with the ack.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,   // active low, synchronous
  mem_port_arbiter_if.slave bus
);

  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [WW-1:0] TO_LAST  = WW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_L = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
  logic            if_ack_q, if_ack_d;
  logic            d_ack_q, d_ack_d;
  logic            err_q, err_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [3:0]      mem_wstrb_q, mem_wstrb_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic [31:0]     d_rdata_q, d_rdata_d;
  logic            timeout_hit;

  // The watchdog fires on the last allowed busy cycle; TIMEOUT=0 disables it.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == TO_LAST);

  // State and output registers; reset drops any access in flight silently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      err_q        <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      err_q        <= err_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Next-state logic: arbitration in IDLE, completion/watchdog in BUSY,
  // a single ack cycle in RESP.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    err_d        = 1'b0;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        if (bus.d_req && (!bus.if_req || starve_cnt_q != STARVE_L)) begin
          // data grant; only counts as starvation when fetch is waiting
          if (bus.if_req) starve_cnt_d = starve_cnt_q + SW'(1);
          mem_en_d    = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          mem_wstrb_d = bus.d_wstrb;
          state_d     = BUSY_D;
        end else if (bus.if_req) begin
          starve_cnt_d = '0;
          mem_en_d     = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = bus.if_addr;
          mem_wstrb_d  = 4'b0000;
          state_d      = BUSY_I;
        end
      end

      BUSY_I, BUSY_D: begin
        wait_cnt_d = wait_cnt_q + WW'(1);
        // mem_ready is checked first so a late answer beats the watchdog
        if (bus.mem_ready || timeout_hit) begin
          mem_en_d   = 1'b0;
          wait_cnt_d = '0;
          err_d      = !bus.mem_ready;
          state_d    = RESP;
          if (state_q == BUSY_I) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_ready ? bus.mem_rdata : 32'd0;
          end else begin
            d_ack_d = 1'b1;
            if (!bus.mem_ready)  d_rdata_d = 32'd0;
            else if (!mem_we_q)  d_rdata_d = bus.mem_rdata;
          end
        end
      end

      RESP: begin
        wait_cnt_d = '0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.if_ack     = if_ack_q;
  assign bus.d_ack      = d_ack_q;
  assign bus.err        = err_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wstrb  = mem_wstrb_q;
  assign bus.core_stall = (bus.if_req & ~if_ack_q) | (bus.d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Cycle k is the interval after the
// k-th rising edge; inputs are set and outputs sampled 1 ns after the edge.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mem_port_arbiter_if bus();
  mem_port_arbiter_if bus_nt();

  mem_port_arbiter #(.TIMEOUT(16), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  mem_port_arbiter #(.TIMEOUT(0), .STARVE_MAX(4)) dut_nt (
    .clk(clk), .rst(rst), .bus(bus_nt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [5:0] fetch_turn;
    int         nt_acks;

    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.d_wstrb = 0;
    bus.mem_rdata = 0; bus.mem_ready = 0;
    bus_nt.if_req = 0; bus_nt.if_addr = 0; bus_nt.d_req = 0; bus_nt.d_we = 0;
    bus_nt.d_addr = 0; bus_nt.d_wdata = 0; bus_nt.d_wstrb = 0;
    bus_nt.mem_rdata = 0; bus_nt.mem_ready = 0;

    // ---- reset with a pending fetch and mem_ready high ----
    bus.if_req = 1; bus.if_addr = 32'h40; bus.mem_ready = 1; bus.mem_rdata = 32'h0BADF00D;
    tick(); tick();
    chk1 ("rst_if_ack",    bus.if_ack, 1'b0);
    chk1 ("rst_d_ack",     bus.d_ack, 1'b0);
    chk1 ("rst_err",       bus.err, 1'b0);
    chk1 ("rst_mem_en",    bus.mem_en, 1'b0);
    chk1 ("rst_mem_we",    bus.mem_we, 1'b0);
    chk32("rst_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
    chk32("rst_mem_addr",  bus.mem_addr, 32'd0);
    chk32("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk32("rst_if_rdata",  bus.if_rdata, 32'd0);
    chk32("rst_d_rdata",   bus.d_rdata, 32'd0);
    rst = 1;                                   // cycle 0: grant fetch
    tick();                                    // cycle 1
    chk1 ("rel_mem_en",    bus.mem_en, 1'b1);
    chk32("rel_mem_addr",  bus.mem_addr, 32'h40);
    chk1 ("rel_stall",     bus.core_stall, 1'b1);
    tick();                                    // cycle 2
    chk1 ("rel_if_ack",    bus.if_ack, 1'b1);
    chk32("rel_if_rdata",  bus.if_rdata, 32'h0BADF00D);
    chk1 ("rel_mem_en_off", bus.mem_en, 1'b0);
    chk1 ("rel_stall_ack", bus.core_stall, 1'b0);
    bus.if_req = 0; bus.mem_ready = 0;
    tick();                                    // cycle 3
    chk1 ("rel_if_ack_pulse", bus.if_ack, 1'b0);

    // ---- fetch with two wait cycles ----
    bus.if_req = 1; bus.if_addr = 32'h100;     // cycle 0
    tick();                                    // cycle 1
    chk1 ("f_mem_en",   bus.mem_en, 1'b1);
    chk32("f_mem_addr", bus.mem_addr, 32'h100);
    chk1 ("f_mem_we",   bus.mem_we, 1'b0);
    tick();                                    // cycle 2
    chk1 ("f_no_ack_w", bus.if_ack, 1'b0);
    tick();                                    // cycle 3
    chk1 ("f_no_ack_w2", bus.if_ack, 1'b0);
    bus.mem_ready = 1; bus.mem_rdata = 32'h00500093;
    tick();                                    // cycle 4
    chk1 ("f_if_ack",   bus.if_ack, 1'b1);
    chk32("f_if_rdata", bus.if_rdata, 32'h00500093);
    chk1 ("f_err",      bus.err, 1'b0);
    bus.if_req = 0; bus.mem_ready = 0;
    tick();

    // ---- load to seed d_rdata, store, then load back ----
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h1000; bus.mem_ready = 1;
    bus.mem_rdata = 32'h11223344;
    tick(); tick();
    chk1 ("ld0_d_ack",   bus.d_ack, 1'b1);
    chk32("ld0_d_rdata", bus.d_rdata, 32'h11223344);
    bus.d_req = 0;
    tick();
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2000; bus.d_wdata = 32'hDEADBEEF;
    bus.d_wstrb = 4'b0011; bus.mem_rdata = 32'hFFFFFFFF;
    tick();
    chk1 ("st_mem_we",    bus.mem_we, 1'b1);
    chk32("st_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'h3);
    chk32("st_mem_addr",  bus.mem_addr, 32'h2000);
    chk32("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    tick();
    chk1 ("st_d_ack",     bus.d_ack, 1'b1);
    chk32("st_d_rdata",   bus.d_rdata, 32'h11223344);
    bus.d_req = 0;
    tick();
    bus.d_req = 1; bus.d_we = 0; bus.d_wstrb = 4'b0000; bus.mem_rdata = 32'h0000BEEF;
    tick();
    chk1 ("ld_mem_we",    bus.mem_we, 1'b0);
    tick();
    chk1 ("ld_d_ack",     bus.d_ack, 1'b1);
    chk32("ld_d_rdata",   bus.d_rdata, 32'h0000BEEF);
    bus.d_req = 0; bus.mem_ready = 0;
    tick();

    // ---- priority and starvation: expected grants D,D,D,D,I,D ----
    fetch_turn = 6'b010000;
    bus.if_req = 1; bus.if_addr = 32'h300;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h400;
    bus.mem_ready = 1; bus.mem_rdata = 32'hCAFEF00D;
    for (int g = 0; g < 6; g++) begin
      tick();
      chk32($sformatf("prio_addr_%0d", g), bus.mem_addr,
            fetch_turn[g] ? 32'h300 : 32'h400);
      tick();
      chk1($sformatf("prio_if_ack_%0d", g), bus.if_ack, fetch_turn[g]);
      chk1($sformatf("prio_d_ack_%0d", g), bus.d_ack, !fetch_turn[g]);
      if (g == 5) begin
        bus.if_req = 0; bus.d_req = 0;
      end
      tick();
    end
    bus.mem_ready = 0;

    // ---- watchdog: TIMEOUT=16, memory never answers ----
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h500; bus.mem_rdata = 32'h55555555;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk1($sformatf("to_no_ack_%0d", c), bus.d_ack, 1'b0);
      chk1($sformatf("to_mem_en_%0d", c), bus.mem_en, 1'b1);
    end
    tick();                                    // cycle 17
    chk1 ("to_d_ack",   bus.d_ack, 1'b1);
    chk1 ("to_err",     bus.err, 1'b1);
    chk32("to_d_rdata", bus.d_rdata, 32'd0);
    chk1 ("to_mem_en",  bus.mem_en, 1'b0);
    bus.d_req = 0;
    tick();                                    // cycle 18: back in IDLE
    chk1 ("to_ack_pulse", bus.d_ack, 1'b0);
    chk1 ("to_err_pulse", bus.err, 1'b0);
    bus.if_req = 1; bus.if_addr = 32'h700; bus.mem_ready = 1; bus.mem_rdata = 32'h00000013;
    tick();
    chk1 ("to_idle_mem_en", bus.mem_en, 1'b1);
    chk32("to_idle_addr",   bus.mem_addr, 32'h700);
    tick();
    chk1 ("to_idle_if_ack", bus.if_ack, 1'b1);
    bus.if_req = 0; bus.mem_ready = 0;
    tick();

    // ---- watchdog disabled: TIMEOUT=0 never acks ----
    bus_nt.d_req = 1; bus_nt.d_addr = 32'h900;
    nt_acks = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (bus_nt.d_ack || bus_nt.if_ack) nt_acks++;
    end
    chk32("nt_ack_count", nt_acks, 32'd0);
    chk1 ("nt_mem_en",    bus_nt.mem_en, 1'b1);
    chk1 ("nt_err",       bus_nt.err, 1'b0);
    bus_nt.d_req = 0;

    // ---- reset in the third BUSY_D cycle ----
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h800;
    tick(); tick(); tick();                    // cycle 3 of BUSY_D
    rst = 0; bus.mem_ready = 1; bus.mem_rdata = 32'h00000077; bus.d_req = 0;
    tick();
    chk1 ("mr_mem_en",  bus.mem_en, 1'b0);
    chk1 ("mr_d_ack",   bus.d_ack, 1'b0);
    chk32("mr_d_rdata", bus.d_rdata, 32'd0);
    rst = 1; bus.mem_ready = 0;
    tick();
    chk1 ("mr_d_ack2",  bus.d_ack, 1'b0);
    bus.if_req = 1; bus.if_addr = 32'h600; bus.mem_ready = 1; bus.mem_rdata = 32'h00000013;
    tick();
    chk1 ("mr_f_mem_en",  bus.mem_en, 1'b1);
    chk32("mr_f_addr",    bus.mem_addr, 32'h600);
    chk1 ("mr_d_ack3",    bus.d_ack, 1'b0);
    tick();
    chk1 ("mr_f_if_ack",  bus.if_ack, 1'b1);
    chk32("mr_f_rdata",   bus.if_rdata, 32'h00000013);
    chk1 ("mr_f_err",     bus.err, 1'b0);
    chk1 ("mr_d_ack4",    bus.d_ack, 1'b0);
    bus.if_req = 0; bus.mem_ready = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch path and the load/store path of the RV32 core, replacing separate inst_mem/data_mem.
- Registers each request, drives the memory port until the memory signals ready, and returns data with a one-cycle acknowledge.
- Gives data priority, with a starvation guard for fetch, and a watchdog that aborts hung accesses.

Parameters:
- TIMEOUT, 16: BUSY cycles without mem_ready before abort; 0 disables the watchdog.
- STARVE_MAX, 4: consecutive data grants allowed while fetch is pending; the next grant then goes to fetch.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  32  fetch address, stable while if_req
- if_ack  out  1  one-cycle fetch completion pulse
- if_rdata  out  32  fetched instruction, valid when if_ack
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_wstrb  in  4  store byte enables
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  32  load data, valid when d_ack
- err  out  1  with an ack pulse, marks a timed-out access
- core_stall  out  1  (if_req & ~if_ack) | (d_req & ~d_ack), combinational
- mem_en  out  1  memory access active
- mem_we  out  1  memory write
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_wstrb  out  4  memory byte enables
- mem_rdata  in  32  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes access this cycle

Behaviour:
- Reset: rst low at a rising edge forces the following state, regardless of state:
  - FSM = IDLE.
  - Outputs 0: if_ack, d_ack, err, mem_en, mem_we, mem_wstrb, if_rdata, d_rdata.
  - Counters 0: wait_cnt, starve_cnt.
  - mem_addr and mem_wdata are 0.
- Reset mid-access: the access is dropped silently and no ack is produced.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - Both requests pending:
    - Grant fetch if starve_cnt == STARVE_MAX, else grant data.
    - Granting data with fetch pending increments starve_cnt.
    - Granting fetch clears starve_cnt.
  - d_req only: grant data; starve_cnt is unchanged.
  - if_req only: grant fetch; starve_cnt = 0.
  - A grant registers the address, data, strobes and we into the mem_* outputs and moves to BUSY_I or BUSY_D.
  - Fetch grants force mem_we=0 and mem_wstrb=0.
- BUSY_x:
  - mem_en=1; mem_* outputs are held constant.
  - wait_cnt increments every cycle.
  - mem_ready=1: latch mem_rdata into if_rdata or d_rdata. Loads only; stores leave d_rdata unchanged. Go to RESP with err=0.
  - TIMEOUT!=0, wait_cnt == TIMEOUT-1 and mem_ready=0: go to RESP with err=1; the rdata register for that port is loaded with 0.
  - mem_ready takes precedence over timeout in the same cycle.
- RESP:
  - The matching ack is 1 for exactly this cycle; err is valid with it.
  - mem_en=0 and wait_cnt=0.
  - Requests are ignored in RESP; the requester must drop or change req by the next edge.
  - Return to IDLE.
- Latency: req seen in IDLE at cycle 0 → mem_en from cycle 1 → mem_ready in cycle 1+W (W≥0 wait cycles) → ack in cycle 2+W.
  - Minimum 3 cycles between back-to-back grants.
- mem_ready outside BUSY is ignored.
- A req deasserted mid-access is illegal; the access still completes and acks.
- Addresses are passed unmodified; alignment is not checked.

Test Plan:
- Reset/idle: hold rst=0 for 2 cycles with if_req=1 → all outputs 0. Release rst, with mem_ready tied to 1 from cycle 1 → mem_en=1 in cycle 1, if_ack=1 in cycle 2.
- Fetch read: if_addr=0x100, memory returns 0x00500093 with mem_ready after 2 wait cycles → mem_addr=0x100, mem_we=0, if_ack in cycle 4, if_rdata=0x00500093, err=0.
- Store then load:
  - d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=4'b0011 → mem_we=1 with mem_wstrb=0011; d_ack fires and d_rdata is unchanged.
  - Load from 0x2000 → d_rdata equals mem_rdata.
- Priority and starvation: if_req and d_req held high, data re-requesting after each ack, STARVE_MAX=4 → grant sequence D,D,D,D,I,D…; fetch is granted on the 5th grant.
- Timeout: TIMEOUT=16, mem_ready never asserted → d_ack=1 and err=1 exactly 17 cycles after grant, d_rdata=0, FSM back in IDLE. Repeat with TIMEOUT=0 → no ack after 100 cycles.
- Reset mid-access: rst=0 during cycle 3 of BUSY_D → no d_ack ever; mem_en=0 next cycle; a fresh fetch after release completes normally.
